// File: rtl/uart_rx_pkg.sv
// Shared UART RX constants: legal oversampling ratios, fallback ratio and idle line level.
// Helper functions classify a raw prescale value and map it onto the ratio actually used.
package uart_rx_pkg;

    localparam int unsigned PRESCALE_W = 6;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8       = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16      = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32      = 6'd32;
    localparam logic [PRESCALE_W-1:0] DEFAULT_PRESCALE = PRESCALE_8;

    localparam logic IDLE_LEVEL = 1'b1;

    // True when p is one of the supported oversampling ratios.
    function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

    // Illegal ratios fall back to the default so the counters always see a sane period.
    function automatic logic [PRESCALE_W-1:0] effective_prescale(input logic [PRESCALE_W-1:0] p);
        return prescale_legal(p) ? p : DEFAULT_PRESCALE;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter for the UART RX path.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   edge_bit_en   - count enable; when low both counters clear on the next edge
//   prescale_eff  - effective (already legalised) oversampling ratio P
//   edge_count    - edge index within the current bit, 0..P-1
//   bit_count     - bit index within the frame, saturating at DATA_WIDTH+2
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  edge_bit_en,
    input  logic [PRESCALE_W-1:0] prescale_eff,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [3:0]            bit_count
);

    localparam logic [3:0] BIT_MAX = 4'(DATA_WIDTH + 2);

    logic edge_wrap;

    // ">=" rather than "==" so a ratio shrinking below the current edge index still wraps.
    assign edge_wrap = (edge_count >= (prescale_eff - 6'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!edge_bit_en) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (edge_wrap) begin
            edge_count <= '0;
            if (bit_count != BIT_MAX) begin
                bit_count <= bit_count + 4'd1;
            end
        end else begin
            edge_count <= edge_count + 6'd1;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART RX front end: input synchronizer, edge/bit counters and 3-sample majority vote.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   s_data            - raw serial line (idle high)
//   prescale          - oversampling ratio; 8, 16 or 32 are legal, others act as 8
//   edge_bit_en       - counter enable from the RX FSM
//   data_sampling_en  - sampler enable from the RX FSM
//   s_data_sync       - synchronized serial line
//   edge_count        - oversample edge index within the current bit
//   bit_count         - bit index within the frame (start bit = 0)
//   sampled_bit       - majority-voted value of the current bit
//   prescale_err      - registered illegal-prescale flag
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_data,
    input  logic [5:0] prescale,
    input  logic       edge_bit_en,
    input  logic       data_sampling_en,
    output logic       s_data_sync,
    output logic [5:0] edge_count,
    output logic [3:0] bit_count,
    output logic       sampled_bit,
    output logic       prescale_err
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [PRESCALE_W-1:0]  prescale_eff;
    logic [PRESCALE_W-1:0]  half;
    logic [PRESCALE_W-1:0]  edge_s0;
    logic [PRESCALE_W-1:0]  edge_s1;
    logic [PRESCALE_W-1:0]  edge_s2;
    logic [PRESCALE_W-1:0]  edge_vote;
    logic [2:0]             samples;
    logic [2:0]             sample_ok;
    logic                   majority;

    assign prescale_eff = effective_prescale(prescale);
    assign half         = prescale_eff >> 1;
    assign edge_s0      = half - 6'd1;
    assign edge_s1      = half;
    assign edge_s2      = half + 6'd1;
    assign edge_vote    = half + 6'd2;
    assign majority     = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                          (samples[1] & samples[2]);
    assign s_data_sync  = sync_q[SYNC_STAGES-1];

    // Metastability synchronizer; resets to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], s_data};
        end
    end

    // Registered illegal-ratio flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_err <= 1'b0;
        end else begin
            prescale_err <= !prescale_legal(prescale);
        end
    end

    uart_rx_edge_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .edge_bit_en  (edge_bit_en),
        .prescale_eff (prescale_eff),
        .edge_count   (edge_count),
        .bit_count    (bit_count)
    );

    // Sample around mid-bit; sample_ok tracks which samples belong to the current
    // enabled window so a window broken by a sampling-enable drop never votes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samples     <= {3{IDLE_LEVEL}};
            sample_ok   <= '0;
            sampled_bit <= IDLE_LEVEL;
        end else if (!data_sampling_en) begin
            sample_ok <= '0;
        end else begin
            if (edge_count == edge_s0) begin
                samples[0]   <= s_data_sync;
                sample_ok[0] <= 1'b1;
            end
            if (edge_count == edge_s1) begin
                samples[1]   <= s_data_sync;
                sample_ok[1] <= 1'b1;
            end
            if (edge_count == edge_s2) begin
                samples[2]   <= s_data_sync;
                sample_ok[2] <= 1'b1;
            end
            if (edge_count == edge_vote) begin
                if (&sample_ok) begin
                    sampled_bit <= majority;
                end
                sample_ok <= '0;
            end
        end
    end

endmodule

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame; bounds the bit counter.
REQ-002 Parameter: SYNC_STAGES, 2, depth of the s_data input synchronizer (minimum 2).
REQ-003 The block SHALL run on one clock; reset SHALL be asynchronous and active-high.
REQ-004 Port: clk  in  1  single clock; all flops on the rising edge.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Port: s_data  in  1  raw serial RX line, idle high.
REQ-007 Port: prescale  in  6  oversampling ratio; legal values are 8, 16 and 32.
REQ-008 Port: edge_bit_en  in  1  counter enable from the RX FSM.
REQ-009 Port: data_sampling_en  in  1  sampler enable from the RX FSM.
REQ-010 Port: s_data_sync  out  1  synchronized serial line, for FSM start detection.
REQ-011 Port: edge_count  out  6  oversample edge index within the current bit.
REQ-012 Port: bit_count  out  4  bit index within the frame (start bit = 0).
REQ-013 Port: sampled_bit  out  1  majority-voted value of the current bit.
REQ-014 Port: prescale_err  out  1  registered flag that prescale holds an illegal value.

Function
REQ-015 s_data SHALL pass through a SYNC_STAGES flop chain with reset value 1; s_data_sync SHALL be the last stage, so latency is SYNC_STAGES cycles.
REQ-016 Effective prescale P SHALL equal prescale when it is 8, 16 or 32, and 8 otherwise.
REQ-017 prescale_err SHALL be set one cycle after prescale becomes illegal, and SHALL clear one cycle after prescale becomes legal again.
REQ-018 While edge_bit_en=1, edge_count SHALL increment every cycle and SHALL wrap from P-1 to 0.
REQ-019 On each edge_count wrap, bit_count SHALL increment by 1.
REQ-020 bit_count SHALL saturate at DATA_WIDTH+2, which is the stop-bit index when parity is present.
REQ-021 While edge_bit_en=0, edge_count and bit_count SHALL be forced to 0 on the next edge, regardless of their current value.
REQ-022 If prescale changes while edge_bit_en=1 and edge_count>=new P, edge_count SHALL wrap to 0 and bit_count SHALL increment.
REQ-023 With data_sampling_en=1, s_data_sync SHALL be captured into three sample flops when edge_count equals P/2-1, P/2 and P/2+1.
REQ-024 sampled_bit SHALL be set to the majority of the three samples on the clock where edge_count equals P/2+2; it is therefore valid from edge P/2+3 until the next update.
REQ-025 sampled_bit SHALL hold its value while data_sampling_en=0; the sample flops SHALL NOT update while data_sampling_en=0.
REQ-026 If data_sampling_en falls mid-bit, the partial sample set SHALL be discarded: no sampled_bit update occurs for that bit.
REQ-027 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-028 On rst: sync chain = all 1s, s_data_sync = 1, edge_count = 0, bit_count = 0, sampled_bit = 1, sample flops = 1, prescale_err = 0.
REQ-029 Reset assertion mid-frame SHALL take effect immediately (asynchronous); after deassertion, counting SHALL restart from 0 on the first edge where edge_bit_en=1.

Structure
REQ-030 A shared package uart_rx_pkg SHALL hold the legal-prescale constants (8/16/32), the default prescale (8) and the idle line level.
REQ-031 The edge/bit counters SHALL live in one sub-module, uart_rx_edge_bit_counter; the synchronizer, sampler and majority vote SHALL stay in uart_rx_sampler.

Verification
REQ-032 Counter wrap: prescale=8, edge_bit_en=1 for 16 cycles -> edge_count 0..7,0..7; bit_count 0 then 1 then 2.
REQ-033 Majority vote: prescale=8, samples 1,0,1 at edges 3,4,5 -> sampled_bit=1 at edge 7; with samples 0,0,1 -> sampled_bit=0.
REQ-034 Illegal prescale: prescale=12 -> prescale_err=1 after 1 cycle and edge_count wraps at 7; prescale=16 -> prescale_err=0 and edge_count wraps at 15.
REQ-035 Saturation: DATA_WIDTH=8, prescale=8, edge_bit_en=1 for 120 cycles -> bit_count holds at 10.
REQ-036 Reset mid-frame: rst pulse at bit_count=5, edge_count=3 -> all outputs at reset values in the same cycle, s_data_sync=1.
REQ-037 Enable drop: edge_bit_en and data_sampling_en fall at edge_count=4, prescale=16 -> counters read 0 next cycle and sampled_bit keeps its prior value.
